// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage plus IF/ID pipeline register.
// Holds the PC and issues one instruction-memory request at a time over a
// valid/ready link. The response goes into IF/ID, or into a 1-entry skid
// buffer when it lands during a load-use stall. An EX redirect flushes
// IF/ID and the skid buffer, drops any in-flight response, and refetches
// from the new address.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   stall_i                           hold IF/ID contents (load-use stall)
//   redirect_valid, redirect_pc       taken branch/jump: flush and refetch
//   imem_req_valid/addr/ready         instruction request handshake
//   imem_resp_valid/data              instruction response (1-cycle pulse)
//   if_id_valid/pc/instr              IF/ID pipeline register
//   if_id_rs1/rs2                     source register fields of if_id_instr
module fetch_stage #(
   parameter int unsigned          XLEN      = 32,
   parameter logic [XLEN-1:0]      RESET_PC  = '0,
   parameter logic [31:0]          NOP_INSTR = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall_i,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req_valid,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_req_ready,
   input  logic            imem_resp_valid,
   input  logic [31:0]     imem_resp_data,
   output logic            if_id_valid,
   output logic [XLEN-1:0] if_id_pc,
   output logic [31:0]     if_id_instr,
   output logic [4:0]      if_id_rs1,
   output logic [4:0]      if_id_rs2
);

   localparam int unsigned ILEN = 32;
   localparam int unsigned SW   = 2;

   localparam logic [SW-1:0] S_REQ  = 2'd0;
   localparam logic [SW-1:0] S_WAIT = 2'd1;
   localparam logic [SW-1:0] S_KILL = 2'd2;

   logic [SW-1:0]   state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] infl_pc_q, infl_pc_d;
   logic            buf_valid_q, buf_valid_d;
   logic [XLEN-1:0] buf_pc_q, buf_pc_d;
   logic [ILEN-1:0] buf_instr_q, buf_instr_d;
   logic            if_id_valid_d;
   logic [XLEN-1:0] if_id_pc_d;
   logic [ILEN-1:0] if_id_instr_d;

   logic            req_valid_c;
   logic            accept_c;
   logic            deliver_c;

   // A new request needs an idle link, an empty skid buffer and no flush.
   assign req_valid_c    = !rst && (state_q == S_REQ) && !buf_valid_q && !redirect_valid;
   assign accept_c       = req_valid_c && imem_req_ready;
   // Only a response to a live (not killed) request is delivered.
   assign deliver_c      = (state_q == S_WAIT) && imem_resp_valid;

   assign imem_req_valid = req_valid_c;
   assign imem_req_addr  = pc_q;
   assign if_id_rs1      = if_id_instr[19:15];
   assign if_id_rs2      = if_id_instr[24:20];

   // Next-state: fetch FSM, PC, skid buffer and IF/ID update.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      infl_pc_d     = infl_pc_q;
      buf_valid_d   = buf_valid_q;
      buf_pc_d      = buf_pc_q;
      buf_instr_d   = buf_instr_q;
      if_id_valid_d = if_id_valid;
      if_id_pc_d    = if_id_pc;
      if_id_instr_d = if_id_instr;

      case (state_q)
         S_REQ: begin
            if (accept_c) begin
               infl_pc_d = pc_q;
               pc_d      = pc_q + XLEN'(4);
               state_d   = S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem_resp_valid) state_d = S_REQ;
         end
         S_KILL: begin
            if (imem_resp_valid) state_d = S_REQ;
         end
         default: state_d = S_REQ;
      endcase

      if (redirect_valid) begin
         // Flush wins over stall; an in-flight request is drained in S_KILL.
         pc_d          = redirect_pc;
         if_id_valid_d = 1'b0;
         if_id_instr_d = NOP_INSTR;
         buf_valid_d   = 1'b0;
         if (state_q == S_WAIT && !imem_resp_valid) state_d = S_KILL;
      end else if (stall_i) begin
         if (deliver_c) begin
            buf_valid_d = 1'b1;
            buf_pc_d    = infl_pc_q;
            buf_instr_d = imem_resp_data;
         end
      end else if (buf_valid_q) begin
         if_id_valid_d = 1'b1;
         if_id_pc_d    = buf_pc_q;
         if_id_instr_d = buf_instr_q;
         buf_valid_d   = 1'b0;
      end else if (deliver_c) begin
         if_id_valid_d = 1'b1;
         if_id_pc_d    = infl_pc_q;
         if_id_instr_d = imem_resp_data;
      end else begin
         if_id_valid_d = 1'b0;
         if_id_instr_d = NOP_INSTR;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_REQ;
         pc_q        <= RESET_PC;
         infl_pc_q   <= '0;
         buf_valid_q <= 1'b0;
         buf_pc_q    <= '0;
         buf_instr_q <= NOP_INSTR;
         if_id_valid <= 1'b0;
         if_id_pc    <= '0;
         if_id_instr <= NOP_INSTR;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         infl_pc_q   <= infl_pc_d;
         buf_valid_q <= buf_valid_d;
         buf_pc_q    <= buf_pc_d;
         buf_instr_q <= buf_instr_d;
         if_id_valid <= if_id_valid_d;
         if_id_pc    <= if_id_pc_d;
         if_id_instr <= if_id_instr_d;
      end
   end

endmodule
